// File: rtl/pedcx_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pedcx_ctrl_pkg
// Shared definitions for the PE dataflow controller slice and its testbench.
//   - pedcx_state_e : controller state encoding
//   - DEF_NUM_CH    : default number of PE channels
//   - DEF_KLEN_W    : default kernel-length / MAC counter width
//   - DEF_NOUT_W    : default outputs-per-routine / output counter width
// ---------------------------------------------------------------------------
package pedcx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_ACCUM    = 3'd2,
        ST_LATCH    = 3'd3,
        ST_WAIT_OUT = 3'd4,
        ST_DONE     = 3'd5
    } pedcx_state_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_KLEN_W = 8;
    localparam int DEF_NOUT_W = 16;

endpackage

// File: rtl/pedcx_statemachine.sv
// ---------------------------------------------------------------------------
// pedcx_statemachine
// State register, MAC counter, output counter and next-state logic of the
// PE dataflow controller. All strobes are decoded from the registered state.
// Ports:
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_start, i_stop      : routine start request / abort request
//   i_outReady           : downstream accepts the current output
//   i_numOutputsRaw      : unlatched outputs-per-routine (used only in IDLE)
//   i_kernelLen          : latched effective kernel length (never 0)
//   i_numOutputs         : latched outputs-per-routine
//   o_startAccept        : start taken this cycle, config must be latched
//   o_clear/o_mac/o_latch/o_valid/o_busy/o_done : state-decoded strobes
// ---------------------------------------------------------------------------
module pedcx_statemachine
    import pedcx_ctrl_pkg::*;
#(
    parameter int KLEN_W = DEF_KLEN_W,
    parameter int NOUT_W = DEF_NOUT_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_outReady,
    input  logic [NOUT_W-1:0] i_numOutputsRaw,
    input  logic [KLEN_W-1:0] i_kernelLen,
    input  logic [NOUT_W-1:0] i_numOutputs,
    output logic              o_startAccept,
    output logic              o_clear,
    output logic              o_mac,
    output logic              o_latch,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_done
);

    pedcx_state_e      r_state;
    pedcx_state_e      w_nextState;
    logic [KLEN_W-1:0] r_macCnt;
    logic [NOUT_W-1:0] r_outCnt;
    logic              w_handshake;
    logic              w_lastMac;
    logic              w_lastOut;

    // A handshake only counts if no abort arrives in the same cycle,
    // otherwise the partial output is thrown away.
    assign w_handshake = (r_state == ST_WAIT_OUT) && i_outReady && !i_stop;
    assign w_lastMac   = (r_macCnt == i_kernelLen - KLEN_W'(1));
    assign w_lastOut   = (r_outCnt == i_numOutputs - NOUT_W'(1));

    // State register; reset returns to IDLE from anywhere.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // MAC counter restarts in CLEAR and counts ACCUM cycles; output counter
    // restarts when a routine is accepted and counts completed handshakes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_macCnt <= '0;
            r_outCnt <= '0;
        end else begin
            if (r_state == ST_CLEAR) begin
                r_macCnt <= '0;
            end else if (r_state == ST_ACCUM) begin
                r_macCnt <= r_macCnt + KLEN_W'(1);
            end
            if (o_startAccept) begin
                r_outCnt <= '0;
            end else if (w_handshake) begin
                r_outCnt <= r_outCnt + NOUT_W'(1);
            end
        end
    end

    // Next-state and strobe decode. Strobes depend on the state only; the
    // abort override is applied last so it beats every other transition.
    always_comb begin
        w_nextState   = r_state;
        o_startAccept = 1'b0;
        o_clear       = 1'b0;
        o_mac         = 1'b0;
        o_latch       = 1'b0;
        o_valid       = 1'b0;
        o_done        = 1'b0;
        o_busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    o_startAccept = 1'b1;
                    w_nextState   = (i_numOutputsRaw == '0) ? ST_DONE : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                o_clear     = 1'b1;
                w_nextState = ST_ACCUM;
            end
            ST_ACCUM: begin
                o_mac = 1'b1;
                if (w_lastMac) begin
                    w_nextState = ST_LATCH;
                end
            end
            ST_LATCH: begin
                o_latch     = 1'b1;
                w_nextState = ST_WAIT_OUT;
            end
            ST_WAIT_OUT: begin
                o_valid = 1'b1;
                if (w_handshake) begin
                    w_nextState = w_lastOut ? ST_DONE : ST_CLEAR;
                end
            end
            ST_DONE: begin
                o_done      = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
        if (i_stop && (r_state != ST_IDLE)) begin
            w_nextState = ST_IDLE;
        end
    end

endmodule

// File: rtl/pedcx_ctrl.sv
// ---------------------------------------------------------------------------
// pedcx_ctrl
// Multi-channel PE dataflow controller: sequences clear, MAC accumulate,
// output-register load and output handshake for a column of NUM_CH PEs.
// Ports:
//   PEDCX_Clk, PEDCX_Reset    : clock, synchronous active-high reset
//   PEDCX_Start_Routine       : start request (IDLE only)
//   PEDCX_Stop_Routine        : abort request (any state)
//   PEDCX_Kernel_Len          : MAC cycles per output, 0 treated as 1
//   PEDCX_Num_Outputs         : outputs per routine
//   PEDCX_Ch_Mask             : channel enable mask
//   PEDCX_Out_Ready           : downstream accepts current output
//   PEDCX_PE_Clear            : accumulator clear strobe
//   PEDCX_PE_Mac_En           : per-channel MAC enable
//   PEDCX_OutReg_Set          : per-channel output-register load pulse
//   PEDCX_Out_Valid           : result awaiting handshake
//   PEDCX_Busy                : controller not idle
//   PEDCX_Done                : normal completion pulse
// ---------------------------------------------------------------------------
module pedcx_ctrl
    import pedcx_ctrl_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int KLEN_W = DEF_KLEN_W,
    parameter int NOUT_W = DEF_NOUT_W
) (
    input  logic              PEDCX_Clk,
    input  logic              PEDCX_Reset,
    input  logic              PEDCX_Start_Routine,
    input  logic              PEDCX_Stop_Routine,
    input  logic [KLEN_W-1:0] PEDCX_Kernel_Len,
    input  logic [NOUT_W-1:0] PEDCX_Num_Outputs,
    input  logic [NUM_CH-1:0] PEDCX_Ch_Mask,
    input  logic              PEDCX_Out_Ready,
    output logic              PEDCX_PE_Clear,
    output logic [NUM_CH-1:0] PEDCX_PE_Mac_En,
    output logic [NUM_CH-1:0] PEDCX_OutReg_Set,
    output logic              PEDCX_Out_Valid,
    output logic              PEDCX_Busy,
    output logic              PEDCX_Done
);

    logic [KLEN_W-1:0] r_kernelLen;
    logic [NOUT_W-1:0] r_numOutputs;
    logic [NUM_CH-1:0] r_chMask;
    logic              w_startAccept;
    logic              w_clear;
    logic              w_mac;
    logic              w_latch;
    logic              w_valid;
    logic              w_busy;
    logic              w_done;

    // Routine configuration is captured once when a start is accepted so the
    // sequencer can change its inputs freely while a routine runs. A zero
    // kernel length is stored as 1 so ACCUM always lasts at least one cycle.
    always_ff @(posedge PEDCX_Clk) begin
        if (PEDCX_Reset) begin
            r_kernelLen  <= '0;
            r_numOutputs <= '0;
            r_chMask     <= '0;
        end else if (w_startAccept) begin
            r_kernelLen  <= (PEDCX_Kernel_Len == '0) ? KLEN_W'(1) : PEDCX_Kernel_Len;
            r_numOutputs <= PEDCX_Num_Outputs;
            r_chMask     <= PEDCX_Ch_Mask;
        end
    end

    pedcx_statemachine #(
        .KLEN_W (KLEN_W),
        .NOUT_W (NOUT_W)
    ) u_statemachine (
        .i_clk           (PEDCX_Clk),
        .i_reset         (PEDCX_Reset),
        .i_start         (PEDCX_Start_Routine),
        .i_stop          (PEDCX_Stop_Routine),
        .i_outReady      (PEDCX_Out_Ready),
        .i_numOutputsRaw (PEDCX_Num_Outputs),
        .i_kernelLen     (r_kernelLen),
        .i_numOutputs    (r_numOutputs),
        .o_startAccept   (w_startAccept),
        .o_clear         (w_clear),
        .o_mac           (w_mac),
        .o_latch         (w_latch),
        .o_valid         (w_valid),
        .o_busy          (w_busy),
        .o_done          (w_done)
    );

    // Per-channel strobes are the shared strobe gated by the latched mask.
    assign PEDCX_PE_Clear   = w_clear;
    assign PEDCX_PE_Mac_En  = {NUM_CH{w_mac}} & r_chMask;
    assign PEDCX_OutReg_Set = {NUM_CH{w_latch}} & r_chMask;
    assign PEDCX_Out_Valid  = w_valid;
    assign PEDCX_Busy       = w_busy;
    assign PEDCX_Done       = w_done;

endmodule

// File: tb/tb_pedcx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pedcx_ctrl
// Directed testbench for pedcx_ctrl. Each step advances one clock and checks
// the full output vector against the hand-derived state for that cycle.
// ---------------------------------------------------------------------------
module tb_pedcx_ctrl;
    import pedcx_ctrl_pkg::*;

    localparam int NUM_CH = DEF_NUM_CH;
    localparam int KLEN_W = DEF_KLEN_W;
    localparam int NOUT_W = DEF_NOUT_W;

    logic              clk;
    logic              reset;
    logic              start;
    logic              stop;
    logic [KLEN_W-1:0] kernelLen;
    logic [NOUT_W-1:0] numOutputs;
    logic [NUM_CH-1:0] chMask;
    logic              outReady;
    logic              peClear;
    logic [NUM_CH-1:0] macEn;
    logic [NUM_CH-1:0] outRegSet;
    logic              outValid;
    logic              busy;
    logic              done;
    logic [11:0]       obsVec;

    int assertCount = 0;
    int failCount   = 0;

    pedcx_ctrl #(
        .NUM_CH (NUM_CH),
        .KLEN_W (KLEN_W),
        .NOUT_W (NOUT_W)
    ) dut (
        .PEDCX_Clk           (clk),
        .PEDCX_Reset         (reset),
        .PEDCX_Start_Routine (start),
        .PEDCX_Stop_Routine  (stop),
        .PEDCX_Kernel_Len    (kernelLen),
        .PEDCX_Num_Outputs   (numOutputs),
        .PEDCX_Ch_Mask       (chMask),
        .PEDCX_Out_Ready     (outReady),
        .PEDCX_PE_Clear      (peClear),
        .PEDCX_PE_Mac_En     (macEn),
        .PEDCX_OutReg_Set    (outRegSet),
        .PEDCX_Out_Valid     (outValid),
        .PEDCX_Busy          (busy),
        .PEDCX_Done          (done)
    );

    // Packed view: {Clear, Mac_En[3:0], OutReg_Set[3:0], Valid, Busy, Done}
    assign obsVec = {peClear, macEn, outRegSet, outValid, busy, done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector for a given controller state and latched mask.
    function automatic logic [11:0] expFor(input pedcx_state_e s, input logic [3:0] m);
        logic [11:0] v;
        v = '0;
        case (s)
            ST_CLEAR:    v = {1'b1, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0};
            ST_ACCUM:    v = {1'b0, m,    4'b0, 1'b0, 1'b1, 1'b0};
            ST_LATCH:    v = {1'b0, 4'b0, m,    1'b0, 1'b1, 1'b0};
            ST_WAIT_OUT: v = {1'b0, 4'b0, 4'b0, 1'b1, 1'b1, 1'b0};
            ST_DONE:     v = {1'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b1};
            default:     v = '0;
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [11:0] observed,
                               input logic [11:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic p, input int k,
                                 input int n, input logic [3:0] m, input logic r);
        start      = s;
        stop       = p;
        kernelLen  = KLEN_W'(k);
        numOutputs = NOUT_W'(n);
        chMask     = m;
        outReady   = r;
    endtask

    // Advance to the next cycle (sample point #1 after the rising edge).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle, drop start, then compare against the expected state.
    task automatic stepExpect(input string tag, input pedcx_state_e s, input logic [3:0] m);
        tick();
        start = 1'b0;
        checkOutput(tag, obsVec, expFor(s, m));
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 0, 0, 4'b0000, 1'b1);
        tick();
        tick();
        checkOutput("reset_state", obsVec, 12'b0);
        reset = 1'b0;
        tick();
        checkOutput("idle_after_reset", obsVec, 12'b0);

        // K=4, N=1, all channels
        applyStimulus(1'b1, 1'b0, 4, 1, 4'b1111, 1'b1);
        stepExpect("t1_c1_clear", ST_CLEAR, 4'b1111);
        for (int c = 2; c <= 5; c++) stepExpect($sformatf("t1_c%0d_accum", c), ST_ACCUM, 4'b1111);
        stepExpect("t1_c6_latch", ST_LATCH, 4'b1111);
        stepExpect("t1_c7_wait", ST_WAIT_OUT, 4'b1111);
        stepExpect("t1_c8_done", ST_DONE, 4'b1111);
        stepExpect("t1_c9_idle", ST_IDLE, 4'b1111);

        // K=0 (treated as 1), N=3, mask 0101: latch pulses in cycles 3, 7, 11
        applyStimulus(1'b1, 1'b0, 0, 3, 4'b0101, 1'b1);
        for (int j = 0; j < 3; j++) begin
            stepExpect($sformatf("t2_o%0d_clear", j), ST_CLEAR, 4'b0101);
            stepExpect($sformatf("t2_o%0d_accum", j), ST_ACCUM, 4'b0101);
            stepExpect($sformatf("t2_o%0d_latch", j), ST_LATCH, 4'b0101);
            stepExpect($sformatf("t2_o%0d_wait", j), ST_WAIT_OUT, 4'b0101);
        end
        stepExpect("t2_c13_done", ST_DONE, 4'b0101);
        stepExpect("t2_c14_idle", ST_IDLE, 4'b0101);

        // K=2, N=2, ready low for cycles 5..9, handshake in cycle 10
        applyStimulus(1'b1, 1'b0, 2, 2, 4'b1111, 1'b0);
        stepExpect("t3_c1_clear", ST_CLEAR, 4'b1111);
        stepExpect("t3_c2_accum", ST_ACCUM, 4'b1111);
        stepExpect("t3_c3_accum", ST_ACCUM, 4'b1111);
        stepExpect("t3_c4_latch", ST_LATCH, 4'b1111);
        for (int c = 5; c <= 10; c++) stepExpect($sformatf("t3_c%0d_wait", c), ST_WAIT_OUT, 4'b1111);
        outReady = 1'b1;
        stepExpect("t3_c11_clear", ST_CLEAR, 4'b1111);
        stepExpect("t3_c12_accum", ST_ACCUM, 4'b1111);
        stepExpect("t3_c13_accum", ST_ACCUM, 4'b1111);
        stepExpect("t3_c14_latch", ST_LATCH, 4'b1111);
        stepExpect("t3_c15_wait", ST_WAIT_OUT, 4'b1111);
        stepExpect("t3_c16_done", ST_DONE, 4'b1111);
        stepExpect("t3_c17_idle", ST_IDLE, 4'b1111);

        // K=8, stop in cycle 4 (ACCUM): idle from cycle 5, no latch or done
        applyStimulus(1'b1, 1'b0, 8, 1, 4'b1111, 1'b1);
        stepExpect("t4_c1_clear", ST_CLEAR, 4'b1111);
        stepExpect("t4_c2_accum", ST_ACCUM, 4'b1111);
        stepExpect("t4_c3_accum", ST_ACCUM, 4'b1111);
        stepExpect("t4_c4_accum", ST_ACCUM, 4'b1111);
        stop = 1'b1;
        stepExpect("t4_c5_stopped", ST_IDLE, 4'b1111);
        stop = 1'b0;
        for (int c = 6; c <= 12; c++) stepExpect($sformatf("t4_c%0d_idle", c), ST_IDLE, 4'b1111);

        // Restart after abort: K=1, N=1, mask 0011
        applyStimulus(1'b1, 1'b0, 1, 1, 4'b0011, 1'b1);
        stepExpect("t4r_clear", ST_CLEAR, 4'b0011);
        stepExpect("t4r_accum", ST_ACCUM, 4'b0011);
        stepExpect("t4r_latch", ST_LATCH, 4'b0011);
        stepExpect("t4r_wait", ST_WAIT_OUT, 4'b0011);
        stepExpect("t4r_done", ST_DONE, 4'b0011);
        stepExpect("t4r_idle", ST_IDLE, 4'b0011);

        // Stop together with a handshake in WAIT_OUT: abort wins
        applyStimulus(1'b1, 1'b0, 1, 2, 4'b1111, 1'b1);
        stepExpect("t5_clear", ST_CLEAR, 4'b1111);
        stepExpect("t5_accum", ST_ACCUM, 4'b1111);
        stepExpect("t5_latch", ST_LATCH, 4'b1111);
        stepExpect("t5_wait", ST_WAIT_OUT, 4'b1111);
        stop = 1'b1;
        stepExpect("t5_stop_over_hs", ST_IDLE, 4'b1111);
        stop = 1'b0;
        stepExpect("t5_still_idle", ST_IDLE, 4'b1111);

        // Reset in WAIT_OUT, then start+stop together in IDLE is ignored
        applyStimulus(1'b1, 1'b0, 1, 1, 4'b1111, 1'b0);
        stepExpect("t6_clear", ST_CLEAR, 4'b1111);
        stepExpect("t6_accum", ST_ACCUM, 4'b1111);
        stepExpect("t6_latch", ST_LATCH, 4'b1111);
        stepExpect("t6_wait", ST_WAIT_OUT, 4'b1111);
        reset = 1'b1;
        tick();
        checkOutput("t6_reset_midroutine", obsVec, 12'b0);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 3, 2, 4'b1111, 1'b1);
        tick();
        checkOutput("t6_start_stop_ignored", obsVec, 12'b0);
        applyStimulus(1'b0, 1'b0, 3, 2, 4'b1111, 1'b1);
        tick();
        checkOutput("t6_idle_hold", obsVec, 12'b0);

        // N=0: straight to DONE in cycle 1, no PE strobes
        applyStimulus(1'b1, 1'b0, 5, 0, 4'b1111, 1'b1);
        stepExpect("t7_c1_done", ST_DONE, 4'b1111);
        stepExpect("t7_c2_idle", ST_IDLE, 4'b1111);
        stepExpect("t7_c3_idle", ST_IDLE, 4'b1111);

        // Mask 0: sequencing runs, per-channel strobes stay 0
        applyStimulus(1'b1, 1'b0, 1, 1, 4'b0000, 1'b1);
        stepExpect("t8_clear", ST_CLEAR, 4'b0000);
        stepExpect("t8_accum_nomask", ST_ACCUM, 4'b0000);
        stepExpect("t8_latch_nomask", ST_LATCH, 4'b0000);
        stepExpect("t8_wait", ST_WAIT_OUT, 4'b0000);
        stepExpect("t8_done", ST_DONE, 4'b0000);
        stepExpect("t8_idle", ST_IDLE, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
